// File: rtl/top.sv
// Two-operand 4-bit calculator: debounced key capture, signed arithmetic and a
// multiplexed 4-digit 7-segment display with a three-LED stage indicator.
module top #(
  parameter int IN_WIDTH        = 4,
  parameter int ANODE_WIDTH     = 4,
  parameter int SEGMENT_WIDTH   = 7,
  parameter int LED_WIDTH       = 3,
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int SCAN_CYCLES     = 50000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [IN_WIDTH-1:0]      in_number,
  input  logic                     k_1,
  input  logic                     k_2,
  input  logic                     plus_key,
  input  logic                     substract_key,
  input  logic                     devide_key,
  input  logic                     multiply_key,
  output logic [ANODE_WIDTH-1:0]   anode,
  output logic [SEGMENT_WIDTH-1:0] seg,
  output logic [LED_WIDTH-1:0]     led
);

  localparam int NKEYS = 6;
  localparam int RES_W = 10;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SC_W  = $clog2(SCAN_CYCLES + 1);
  localparam int IDX_W = (ANODE_WIDTH > 1) ? $clog2(ANODE_WIDTH) : 1;

  localparam logic [0:0] SRC_LIVE   = 1'b0;
  localparam logic [0:0] SRC_RESULT = 1'b1;

  localparam logic [LED_WIDTH-1:0] LED_IDLE = LED_WIDTH'(1);
  localparam logic [LED_WIDTH-1:0] LED_A    = LED_WIDTH'(2);
  localparam logic [LED_WIDTH-1:0] LED_B    = LED_WIDTH'(4);

  localparam logic [3:0] DIG_E     = 4'd10;
  localparam logic [3:0] DIG_MINUS = 4'd11;

  logic [NKEYS-1:0] key_raw;
  logic [NKEYS-1:0] key_ev;

  // Bit 0 is the highest-priority key.
  assign key_raw = {multiply_key, devide_key, substract_key, plus_key, k_2, k_1};

  genvar gi;
  generate
    for (gi = 0; gi < NKEYS; gi++) begin : g_key
      logic            sync1_q, sync1_d;
      logic            sync2_q, sync2_d;
      logic            stable_q, stable_d;
      logic            ev_q, ev_d;
      logic [DB_W-1:0] cnt_q, cnt_d;

      // The counter only runs while the synchronized level disagrees with the
      // accepted level; any bounce back restarts it from zero.
      always_comb begin
        sync1_d  = key_raw[gi];
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
          if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = sync2_q;
          end else begin
            cnt_d = cnt_q + DB_W'(1);
          end
        end
        ev_d = stable_d & ~stable_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_q  <= 1'b0;
          sync2_q  <= 1'b0;
          stable_q <= 1'b0;
          ev_q     <= 1'b0;
          cnt_q    <= '0;
        end else begin
          sync1_q  <= sync1_d;
          sync2_q  <= sync2_d;
          stable_q <= stable_d;
          ev_q     <= ev_d;
          cnt_q    <= cnt_d;
        end
      end

      assign key_ev[gi] = ev_q;
    end
  endgenerate

  logic [IN_WIDTH-1:0] in_s1_q, in_s1_d;
  logic [IN_WIDTH-1:0] in_s2_q, in_s2_d;
  logic [IN_WIDTH-1:0] in_prev_q, in_prev_d;

  logic [IN_WIDTH-1:0]  a_q, a_d;
  logic [IN_WIDTH-1:0]  b_q, b_d;
  logic [RES_W-1:0]     res_q, res_d;
  logic                 err_q, err_d;
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [0:0]           src_q, src_d;

  logic [RES_W-1:0] a_ext, b_ext;
  logic [RES_W-1:0] sum_w, diff_w, prod_w, quot_w;

  assign a_ext  = RES_W'(a_q);
  assign b_ext  = RES_W'(b_q);
  assign sum_w  = a_ext + b_ext;
  assign diff_w = a_ext - b_ext;
  assign prod_w = a_ext * b_ext;
  assign quot_w = (b_q == '0) ? '0 : (a_ext / b_ext);

  always_comb begin
    in_s1_d   = in_number;
    in_s2_d   = in_s1_q;
    in_prev_d = in_s2_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    err_d     = err_q;
    led_d     = led_q;
    src_d     = src_q;

    if (src_q == SRC_RESULT && in_s2_q != in_prev_q) begin
      src_d = SRC_LIVE;
    end

    // Key events override the switch-change fallback in the same cycle.
    if (key_ev[0]) begin
      a_d   = in_s2_q;
      led_d = LED_A;
      src_d = SRC_LIVE;
    end else if (key_ev[1]) begin
      b_d   = in_s2_q;
      led_d = LED_B;
      src_d = SRC_LIVE;
    end else if (|key_ev[NKEYS-1:2]) begin
      led_d = LED_IDLE;
      src_d = SRC_RESULT;
      err_d = 1'b0;
      if (key_ev[2]) begin
        res_d = sum_w;
      end else if (key_ev[3]) begin
        res_d = diff_w;
      end else if (key_ev[4]) begin
        res_d = quot_w;
        err_d = (b_q == '0);
      end else begin
        res_d = prod_w;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_s1_q   <= '0;
      in_s2_q   <= '0;
      in_prev_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      err_q     <= 1'b0;
      led_q     <= LED_IDLE;
      src_q     <= SRC_LIVE;
    end else begin
      in_s1_q   <= in_s1_d;
      in_s2_q   <= in_s2_d;
      in_prev_q <= in_prev_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      err_q     <= err_d;
      led_q     <= led_d;
      src_q     <= src_d;
    end
  end

  assign led = led_q;

  logic [SC_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0] scan_idx_q, scan_idx_d;

  always_comb begin
    scan_cnt_d = scan_cnt_q + SC_W'(1);
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SC_W'(SCAN_CYCLES - 1)) begin
      scan_cnt_d = '0;
      scan_idx_d = (scan_idx_q == IDX_W'(ANODE_WIDTH - 1)) ? '0 : scan_idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
    end
  end

  generate
    for (gi = 0; gi < ANODE_WIDTH; gi++) begin : g_anode
      assign anode[gi] = (scan_idx_q == IDX_W'(gi));
    end
  endgenerate

  logic [RES_W-1:0] disp_val, disp_mag;
  logic             disp_neg, show_err;
  logic [3:0]       d_ones, d_tens, d_hund, digit_code;
  logic [6:0]       seg_code;

  assign disp_val = (src_q == SRC_RESULT) ? res_q : RES_W'(in_s2_q);
  assign disp_neg = disp_val[RES_W-1];
  assign disp_mag = disp_neg ? (~disp_val + RES_W'(1)) : disp_val;
  assign d_ones   = 4'(disp_mag % RES_W'(10));
  assign d_tens   = 4'((disp_mag / RES_W'(10)) % RES_W'(10));
  assign d_hund   = 4'((disp_mag / RES_W'(100)) % RES_W'(10));
  assign show_err = err_q && (src_q == SRC_RESULT);

  always_comb begin
    digit_code = 4'd0;
    case (scan_idx_q)
      IDX_W'(0): digit_code = show_err ? DIG_E : d_ones;
      IDX_W'(1): digit_code = show_err ? 4'd0 : d_tens;
      IDX_W'(2): digit_code = show_err ? 4'd0 : d_hund;
      IDX_W'(3): digit_code = (!show_err && disp_neg) ? DIG_MINUS : 4'd0;
      default:   digit_code = 4'd0;
    endcase
  end

  always_comb begin
    seg_code = 7'b0000000;
    case (digit_code)
      4'd0:    seg_code = 7'b1111110;
      4'd1:    seg_code = 7'b0110000;
      4'd2:    seg_code = 7'b1101101;
      4'd3:    seg_code = 7'b1111001;
      4'd4:    seg_code = 7'b0110011;
      4'd5:    seg_code = 7'b1011011;
      4'd6:    seg_code = 7'b1011111;
      4'd7:    seg_code = 7'b1110000;
      4'd8:    seg_code = 7'b1111111;
      4'd9:    seg_code = 7'b1111011;
      DIG_E:   seg_code = 7'b1001111;
      DIG_MINUS: seg_code = 7'b0000001;
      default: seg_code = 7'b0000000;
    endcase
  end

  assign seg = SEGMENT_WIDTH'(seg_code);

endmodule

// File: tb/tb_top.sv
// Directed bench for the calculator top: expected displays are queued when the
// stimulus is applied and checked digit by digit over one full scan.
module tb_top;

  localparam int DB   = 4;
  localparam int SCAN = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_number;
  logic [5:0] keys;
  logic [3:0] anode;
  logic [6:0] seg;
  logic [2:0] led;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [2:0]  led;
    logic [27:0] segs;
  } exp_t;

  exp_t exp_q[$];

  top #(
    .DEBOUNCE_CYCLES(DB),
    .SCAN_CYCLES(SCAN)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_number(in_number),
    .k_1(keys[0]),
    .k_2(keys[1]),
    .plus_key(keys[2]),
    .substract_key(keys[3]),
    .devide_key(keys[4]),
    .multiply_key(keys[5]),
    .anode(anode),
    .seg(seg),
    .led(led)
  );

  always #10 clk = ~clk;

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg_of(int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      10: return 7'b1001111;
      default: return 7'b0000001;
    endcase
  endfunction

  function automatic logic [27:0] model_segs(int v, bit err);
    logic [27:0] r;
    int m;
    if (err) begin
      r = {seg_of(0), seg_of(0), seg_of(0), seg_of(10)};
    end else begin
      m = (v < 0) ? -v : v;
      r[6:0]   = seg_of(m % 10);
      r[13:7]  = seg_of((m / 10) % 10);
      r[20:14] = seg_of((m / 100) % 10);
      r[27:21] = (v < 0) ? seg_of(11) : seg_of(0);
    end
    return r;
  endfunction

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(int k);
    keys[k] = 1'b1;
    cyc(DB + 8);
    keys[k] = 1'b0;
    cyc(DB + 8);
  endtask

  task automatic push_expect(logic [2:0] l, int v, bit err);
    exp_t e;
    e.led  = l;
    e.segs = model_segs(v, err);
    exp_q.push_back(e);
  endtask

  task automatic check_led(string tag, logic [2:0] e);
    vectors++;
    assert (led === e) else begin
      miscompares++;
      $error("FAIL %s led: observed %b expected %b", tag, led, e);
    end
  endtask

  task automatic check_display(string tag);
    exp_t e;
    int n;
    logic [3:0] ea;
    vectors++;
    assert (exp_q.size() > 0) else begin
      miscompares++;
      $error("FAIL %s queue: observed empty expected an entry", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_led(tag, e.led);
      n = 0;
      while (anode === 4'b0001 && n < 10 * SCAN) begin cyc(1); n++; end
      while (anode !== 4'b0001 && n < 10 * SCAN) begin cyc(1); n++; end
      vectors++;
      assert (n < 10 * SCAN) else begin
        miscompares++;
        $error("FAIL %s scan: observed timeout anode=%b expected 0001", tag, anode);
      end
      for (int d = 0; d < 4; d++) begin
        ea = 4'b0001 << d;
        vectors++;
        assert (anode === ea) else begin
          miscompares++;
          $error("FAIL %s anode%0d: observed %b expected %b", tag, d, anode, ea);
        end
        vectors++;
        assert (seg === e.segs[d*7 +: 7]) else begin
          miscompares++;
          $error("FAIL %s seg%0d: observed %b expected %b", tag, d, seg, e.segs[d*7 +: 7]);
        end
        if (d < 3) cyc(SCAN);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    keys      = '0;
    in_number = 4'd7;
    cyc(3);
    rst_n = 1'b1;

    // Reset state shows the live switches.
    check_led("reset", 3'b001);
    push_expect(3'b001, 7, 1'b0);
    check_display("reset_live7");

    // 9 + 6
    in_number = 4'd9; press(0); check_led("a9", 3'b010);
    in_number = 4'd6; press(1); check_led("b6", 3'b100);
    press(2);
    push_expect(3'b001, 15, 1'b0);
    check_display("add_9_6");

    // 3 - 12, then switch change drops back to live
    in_number = 4'd3;  press(0);
    in_number = 4'd12; press(1);
    press(3);
    push_expect(3'b001, -9, 1'b0);
    check_display("sub_3_12");
    in_number = 4'd4;
    push_expect(3'b001, 4, 1'b0);
    cyc(6);
    check_display("live_after_result");

    // 15 * 15
    in_number = 4'd15; press(0); press(1); press(5);
    push_expect(3'b001, 225, 1'b0);
    check_display("mul_15_15");

    // 13 / 4, then divide by zero
    in_number = 4'd13; press(0);
    in_number = 4'd4;  press(1); press(4);
    push_expect(3'b001, 3, 1'b0);
    check_display("div_13_4");
    in_number = 4'd0; press(1); press(4);
    push_expect(3'b001, 0, 1'b1);
    check_display("div_by_zero");

    // Simultaneous k_1 and k_2: only k_1 is taken, B stays 0
    in_number = 4'd5;
    keys[0] = 1'b1; keys[1] = 1'b1;
    cyc(DB + 8);
    keys[0] = 1'b0; keys[1] = 1'b0;
    cyc(DB + 8);
    check_led("prio_k1", 3'b010);
    press(2);
    push_expect(3'b001, 5, 1'b0);
    check_display("prio_sum");

    // Reset mid-press clears A, B and pending debounce
    in_number = 4'd2;
    keys[0] = 1'b1;
    cyc(4);
    rst_n = 1'b0;
    cyc(2);
    keys[0] = 1'b0;
    rst_n = 1'b1;
    cyc(DB + 8);
    check_led("mid_reset", 3'b001);
    push_expect(3'b001, 2, 1'b0);
    check_display("mid_reset_live");
    press(2);
    push_expect(3'b001, 0, 1'b0);
    check_display("mid_reset_sum");

    // Full A+B sweep, k_2 re-pressed without k_1
    for (int a = 0; a < 16; a++) begin
      in_number = 4'(a);
      press(0);
      for (int b = 0; b < 16; b++) begin
        in_number = 4'(b);
        press(1);
        check_led($sformatf("sweep_b_%0d_%0d", a, b), 3'b100);
        press(2);
        push_expect(3'b001, a + b, 1'b0);
        check_display($sformatf("sweep_%0d_%0d", a, b));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
